// File: rtl/dft_pkg.sv
// Shared constants, complex sample type, state encodings and the size-code to
// point-count table used by the DFT output path.
package dft_pkg;

  localparam int DFT_DW        = 18;
  localparam int DFT_AW        = 11;
  localparam int DFT_MAXPTS    = 1200;
  localparam int DFT_NUM_SIZES = 34;

  typedef struct packed {
    logic signed [DFT_DW-1:0] re;
    logic signed [DFT_DW-1:0] im;
  } cplx_t;

  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Same table as the DFT top: every legal size is 12 * 2^a * 3^b * 5^c up to 1200.
  // Illegal codes fall back to the smallest size so a frame is still emitted.
  function automatic logic [DFT_AW-1:0] size_to_pts(input logic [5:0] code);
    case (code)
      6'd0:    return 11'd12;
      6'd1:    return 11'd24;
      6'd2:    return 11'd36;
      6'd3:    return 11'd48;
      6'd4:    return 11'd60;
      6'd5:    return 11'd72;
      6'd6:    return 11'd96;
      6'd7:    return 11'd108;
      6'd8:    return 11'd120;
      6'd9:    return 11'd144;
      6'd10:   return 11'd180;
      6'd11:   return 11'd192;
      6'd12:   return 11'd216;
      6'd13:   return 11'd240;
      6'd14:   return 11'd288;
      6'd15:   return 11'd300;
      6'd16:   return 11'd324;
      6'd17:   return 11'd360;
      6'd18:   return 11'd384;
      6'd19:   return 11'd432;
      6'd20:   return 11'd480;
      6'd21:   return 11'd540;
      6'd22:   return 11'd576;
      6'd23:   return 11'd600;
      6'd24:   return 11'd648;
      6'd25:   return 11'd720;
      6'd26:   return 11'd768;
      6'd27:   return 11'd864;
      6'd28:   return 11'd900;
      6'd29:   return 11'd960;
      6'd30:   return 11'd972;
      6'd31:   return 11'd1080;
      6'd32:   return 11'd1152;
      6'd33:   return 11'd1200;
      default: return 11'd12;
    endcase
  endfunction

  function automatic logic size_code_bad(input logic [5:0] code);
    return code >= 6'(DFT_NUM_SIZES);
  endfunction

endpackage

// File: rtl/dft_pingpong_ram.sv
// Two-bank sample store for the DFT output stage: one write port and one read
// port, each with its own bank select, registered read data (1-cycle latency).
module dft_pingpong_ram #(
  parameter int DW    = 18,
  parameter int AW    = 11,
  parameter int DEPTH = 1200
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic            wr_bank,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2*DW-1:0] wr_data,
  input  logic            rd_en,
  input  logic            rd_bank,
  input  logic [AW-1:0]   rd_addr,
  output logic [2*DW-1:0] rd_data
);

  logic [2*DW-1:0] mem0 [DEPTH];
  logic [2*DW-1:0] mem1 [DEPTH];

  // Write port: addresses beyond the bank depth are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < AW'(DEPTH))) begin
      if (wr_bank) mem1[wr_addr] <= wr_data;
      else         mem0[wr_addr] <= wr_data;
    end
  end

  // Read port: data for an address presented in one cycle appears after the next edge.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
    end
  end

endmodule

// File: rtl/dft_source_framer.sv
// Output framer of the mixed-radix DFT core: accepts completed frames into a
// ping-pong store and streams each one out with valid/sop/eop and a per-frame
// block exponent.
module dft_source_framer
  import dft_pkg::*;
#(
  parameter int DW     = DFT_DW,
  parameter int AW     = DFT_AW,
  parameter int MAXPTS = DFT_MAXPTS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_real,
  input  logic signed [DW-1:0] wr_imag,
  input  logic                 frame_done,
  input  logic [5:0]           frame_size,
  input  logic [3:0]           frame_exp,
  output logic                 in_ready,
  output logic                 source_valid,
  output logic                 source_sop,
  output logic                 source_eop,
  output logic signed [DW-1:0] source_real,
  output logic signed [DW-1:0] source_imag,
  output logic [3:0]           source_exp,
  output logic                 overflow,
  output logic                 size_err
);

  bank_state_t   bank_st  [2];
  logic [AW-1:0] bank_pts [2];
  logic [3:0]    bank_exp [2];
  logic          wb;
  logic          rb;

  rd_state_t     rd_state;
  logic [AW-1:0] rd_cnt;
  logic          rd_issue;
  logic          rd_last;
  logic [AW-1:0] rd_addr;

  logic          fd_accept;
  logic          wr_accept;
  cplx_t         wr_sample;
  cplx_t         rd_sample;
  logic [2*DW-1:0] rd_data;

  logic          s1_valid;
  logic          s1_sop;
  logic          s1_eop;
  logic [3:0]    s1_exp;

  assign in_ready  = (bank_st[wb] == BANK_FREE);
  assign fd_accept = frame_done && in_ready;
  assign wr_accept = wr_en && in_ready;

  assign wr_sample.re = wr_real;
  assign wr_sample.im = wr_imag;
  assign rd_sample    = rd_data;

  dft_pingpong_ram #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (MAXPTS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_bank (wb),
    .wr_addr (wr_addr),
    .wr_data (wr_sample),
    .rd_en   (rd_issue),
    .rd_bank (rb),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Address issue: an IDLE reader presents address 0 combinationally so the first
  // sample leaves two edges after frame_done, and the same path closes the gap when
  // the next bank fills on the very edge the previous frame finishes.
  always_comb begin
    rd_issue = 1'b0;
    rd_addr  = '0;
    case (rd_state)
      RD_IDLE: rd_issue = (bank_st[rb] == BANK_FULL);
      RD_READ: begin
        rd_issue = 1'b1;
        rd_addr  = rd_cnt;
      end
      default: rd_issue = 1'b0;
    endcase
    rd_last = rd_issue && (rd_addr == bank_pts[rb] - AW'(1));
  end

  // Bank bookkeeping: a completed frame marks the write bank FULL, the last read frees
  // the read bank; the two always target different banks so both may happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        bank_st[i]  <= BANK_FREE;
        bank_pts[i] <= '0;
        bank_exp[i] <= '0;
      end
      wb <= 1'b0;
      rb <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fd_accept && (wb == 1'(i))) begin
          bank_st[i]  <= BANK_FULL;
          bank_pts[i] <= size_to_pts(frame_size);
          bank_exp[i] <= frame_exp;
        end else if (rd_last && (rb == 1'(i))) begin
          bank_st[i]  <= BANK_FREE;
        end
      end
      if (fd_accept) wb <= ~wb;
      if (rd_last)   rb <= ~rb;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      size_err <= 1'b0;
    end else begin
      if (frame_done && !in_ready)                 overflow <= 1'b1;
      if (fd_accept && size_code_bad(frame_size))  size_err <= 1'b1;
    end
  end

  // Read sequencer: walk 0..pts-1, then hop straight into the other bank if it is
  // already waiting, otherwise park in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= '0;
    end else if (rd_issue) begin
      if (rd_last) begin
        rd_cnt   <= '0;
        rd_state <= (bank_st[~rb] == BANK_FULL) ? RD_READ : RD_IDLE;
      end else begin
        rd_cnt   <= rd_addr + AW'(1);
        rd_state <= RD_READ;
      end
    end
  end

  // Framing flags travel alongside the RAM read so they line up with its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_exp   <= '0;
    end else begin
      s1_valid <= rd_issue;
      s1_sop   <= rd_issue && (rd_addr == '0);
      s1_eop   <= rd_last;
      if (rd_issue) s1_exp <= bank_exp[rb];
    end
  end

  // Registered source interface; payload and exponent hold while no sample is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_real  <= '0;
      source_imag  <= '0;
      source_exp   <= '0;
    end else begin
      source_valid <= s1_valid;
      source_sop   <= s1_valid && s1_sop;
      source_eop   <= s1_valid && s1_eop;
      if (s1_valid) begin
        source_real <= rd_sample.re;
        source_imag <= rd_sample.im;
        source_exp  <= s1_exp;
      end
    end
  end

endmodule
